// File: rtl/oled_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : oled_frame_arbiter
// Function : Frame-granular round-robin arbiter sharing one OLED driver port
//            between an init/command sequencer (0) and a data streamer (1).
//            Optional watchdog release: define OLED_ARB_WATCHDOG_EN.
// Revision : 1.0
// ============================================================================
module oled_frame_arbiter #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk_in,
    input  logic       reset_n_in,
    input  logic       req0_in,
    input  logic       req1_in,
    input  logic [7:0] data0_in,
    input  logic [7:0] data1_in,
    input  logic       write_stb0_in,
    input  logic       write_stb1_in,
    input  logic       sync_stb0_in,
    input  logic       sync_stb1_in,
    output logic       grant0_out,
    output logic       grant1_out,
    output logic       ready0_out,
    output logic       ready1_out,
    output logic [7:0] oled_data_out,
    output logic       oled_write_stb_out,
    output logic       oled_sync_stb_out,
    input  logic       oled_ready_in
`ifdef OLED_ARB_WATCHDOG_EN
    ,
    output logic       timeout_out
`endif
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GRANT0    = 3'd1,
        S_GRANT1    = 3'd2,
        S_SYNC_BUSY = 3'd3,
        S_SYNC_DONE = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // High when requester 1 held the port last; resets high so requester 0 wins first.
    logic   last_grant;
    logic   last_grant_nxt;

    logic   in_grant;
    logic   own_req;
    logic   own_write;
    logic   own_sync;
    logic   own_strobe;
    logic   watchdog_fire;

    assign in_grant   = (state == S_GRANT0) || (state == S_GRANT1);
    assign own_req    = ((state == S_GRANT0) && req0_in)       || ((state == S_GRANT1) && req1_in);
    assign own_write  = ((state == S_GRANT0) && write_stb0_in) || ((state == S_GRANT1) && write_stb1_in);
    assign own_sync   = ((state == S_GRANT0) && sync_stb0_in)  || ((state == S_GRANT1) && sync_stb1_in);
    assign own_strobe = own_write || own_sync;

`ifdef OLED_ARB_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;

    // Held at zero while idle so every new grant starts from a clean count.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            wd_cnt <= '0;
        end else if (!in_grant || own_strobe) begin
            wd_cnt <= '0;
        end else if (wd_cnt != WD_MAX) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Fires in the last silent cycle so the grant drops on the following edge.
    assign watchdog_fire = in_grant && !own_strobe && (wd_cnt >= WD_LAST);
    assign timeout_out   = watchdog_fire;
`else
    assign watchdog_fire = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        last_grant_nxt     = last_grant;
        grant0_out         = 1'b0;
        grant1_out         = 1'b0;
        ready0_out         = 1'b0;
        ready1_out         = 1'b0;
        oled_data_out      = 8'h00;
        oled_write_stb_out = 1'b0;
        oled_sync_stb_out  = 1'b0;

        case (state)
            S_IDLE: begin
                if (oled_ready_in) begin
                    if (req0_in && (!req1_in || last_grant)) begin
                        state_nxt = S_GRANT0;
                    end else if (req1_in) begin
                        state_nxt = S_GRANT1;
                    end
                end
            end
            S_GRANT0, S_GRANT1: begin
                if (own_sync) begin
                    state_nxt      = S_SYNC_BUSY;
                    last_grant_nxt = (state == S_GRANT1);
                end else if (watchdog_fire) begin
                    state_nxt      = S_IDLE;
                    last_grant_nxt = (state == S_GRANT1);
                end else if (!own_req && oled_ready_in && !own_write) begin
                    state_nxt      = S_IDLE;
                    last_grant_nxt = (state == S_GRANT1);
                end
            end
            S_SYNC_BUSY: begin
                if (!oled_ready_in) begin
                    state_nxt = S_SYNC_DONE;
                end
            end
            S_SYNC_DONE: begin
                if (oled_ready_in) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (state == S_GRANT0) begin
            grant0_out         = 1'b1;
            ready0_out         = oled_ready_in;
            oled_data_out      = data0_in;
            oled_write_stb_out = write_stb0_in;
            oled_sync_stb_out  = sync_stb0_in;
        end else if (state == S_GRANT1) begin
            grant1_out         = 1'b1;
            ready1_out         = oled_ready_in;
            oled_data_out      = data1_in;
            oled_write_stb_out = write_stb1_in;
            oled_sync_stb_out  = sync_stb1_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_oled_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_oled_frame_arbiter
// Function : Directed bench for oled_frame_arbiter with a byte scoreboard and
//            a simple OLED driver busy model.
// Revision : 1.0
// ============================================================================
module tb_oled_frame_arbiter;

    logic       clk_in = 1'b0;
    logic       reset_n_in;
    logic       req0_in;
    logic       req1_in;
    logic [7:0] data0_in;
    logic [7:0] data1_in;
    logic       write_stb0_in;
    logic       write_stb1_in;
    logic       sync_stb0_in;
    logic       sync_stb1_in;
    logic       grant0_out;
    logic       grant1_out;
    logic       ready0_out;
    logic       ready1_out;
    logic [7:0] oled_data_out;
    logic       oled_write_stb_out;
    logic       oled_sync_stb_out;
    logic       oled_ready_in;
`ifdef OLED_ARB_WATCHDOG_EN
    logic       timeout_out;
`endif

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] sb_q[$];
    bit         drv_en      = 1'b0;
    int         drv_busy    = 0;

    always #5 clk_in = ~clk_in;

    oled_frame_arbiter #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_in             (clk_in),
        .reset_n_in         (reset_n_in),
        .req0_in            (req0_in),
        .req1_in            (req1_in),
        .data0_in           (data0_in),
        .data1_in           (data1_in),
        .write_stb0_in      (write_stb0_in),
        .write_stb1_in      (write_stb1_in),
        .sync_stb0_in       (sync_stb0_in),
        .sync_stb1_in       (sync_stb1_in),
        .grant0_out         (grant0_out),
        .grant1_out         (grant1_out),
        .ready0_out         (ready0_out),
        .ready1_out         (ready1_out),
        .oled_data_out      (oled_data_out),
        .oled_write_stb_out (oled_write_stb_out),
        .oled_sync_stb_out  (oled_sync_stb_out),
        .oled_ready_in      (oled_ready_in)
`ifdef OLED_ARB_WATCHDOG_EN
        ,
        .timeout_out        (timeout_out)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: mid-cycle monitor (scoreboard, exclusivity, driver model), then past the edge.
    task automatic cyc();
        logic       exp_wr;
        logic [7:0] exp_byte;
        @(negedge clk_in);
        check("grant_exclusive", 32'(grant0_out & grant1_out), 32'd0);
        exp_wr = (sb_q.size() != 0);
        check("sb_write_stb", 32'(oled_write_stb_out), 32'(exp_wr));
        if (exp_wr) begin
            exp_byte = sb_q.pop_front();
            check("sb_write_data", 32'(oled_data_out), 32'(exp_byte));
        end
        if (drv_en && (oled_write_stb_out === 1'b1 || oled_sync_stb_out === 1'b1)) begin
            drv_busy = 3;
        end
        @(posedge clk_in);
        #1;
        if (drv_en) begin
            if (drv_busy > 0) begin
                oled_ready_in = 1'b0;
                drv_busy--;
            end else begin
                oled_ready_in = 1'b1;
            end
        end
        #1;
    endtask

    task automatic drive_write(input int who, input logic [7:0] b);
        if (who == 0) begin
            write_stb0_in = 1'b1;
            data0_in      = b;
        end else begin
            write_stb1_in = 1'b1;
            data1_in      = b;
        end
        sb_q.push_back(b);
        cyc();
        write_stb0_in = 1'b0;
        write_stb1_in = 1'b0;
    endtask

    task automatic wait_ready(input int who, input string tag);
        int n = 0;
        while (((who == 0) ? ready0_out : ready1_out) !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        check(tag, 32'((who == 0) ? ready0_out : ready1_out), 32'd1);
    endtask

    task automatic send_frame(input int who, input logic [7:0] base);
        for (int i = 0; i < 4; i++) begin
            wait_ready(who, "frame_byte_ready");
            drive_write(who, base + 8'(i));
        end
        wait_ready(who, "frame_sync_ready");
        if (who == 0) sync_stb0_in = 1'b1;
        else          sync_stb1_in = 1'b1;
        #1;
        check("frame_sync_fwd", 32'(oled_sync_stb_out), 32'd1);
        cyc();
        sync_stb0_in = 1'b0;
        sync_stb1_in = 1'b0;
        check("frame_release", 32'(grant0_out | grant1_out), 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL bench_timeout: observed no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        int owner;

        reset_n_in    = 1'b0;
        oled_ready_in = 1'b1;
        req0_in       = 1'b1;
        req1_in       = 1'b0;
        data0_in      = 8'hA5;
        data1_in      = 8'h00;
        write_stb0_in = 1'b1;
        write_stb1_in = 1'b0;
        sync_stb0_in  = 1'b1;
        sync_stb1_in  = 1'b0;

        // Reset holds everything quiet even with a live request and strobes.
        cyc();
        cyc();
        check("rst_grant0", 32'(grant0_out), 32'd0);
        check("rst_grant1", 32'(grant1_out), 32'd0);
        check("rst_ready0", 32'(ready0_out), 32'd0);
        check("rst_data", 32'(oled_data_out), 32'd0);
        check("rst_write", 32'(oled_write_stb_out), 32'd0);
        check("rst_sync", 32'(oled_sync_stb_out), 32'd0);
        write_stb0_in = 1'b0;
        sync_stb0_in  = 1'b0;

        // First arbitration one edge after release; same-cycle byte pass-through.
        reset_n_in = 1'b1;
        #1;
        check("arb_not_early", 32'(grant0_out), 32'd0);
        cyc();
        check("first_grant0", 32'(grant0_out), 32'd1);
        check("first_ready0", 32'(ready0_out), 32'd1);
        check("first_grant1", 32'(grant1_out), 32'd0);
        data0_in      = 8'hA5;
        write_stb0_in = 1'b1;
        sb_q.push_back(8'hA5);
        #1;
        check("passthru_stb", 32'(oled_write_stb_out), 32'd1);
        check("passthru_data", 32'(oled_data_out), 32'hA5);
        cyc();
        write_stb0_in = 1'b0;

        // Owner 0 drops request; pending requester 1 follows after idle.
        req0_in = 1'b0;
        req1_in = 1'b1;
        cyc();
        check("abort_idle_g0", 32'(grant0_out), 32'd0);
        check("abort_idle_g1", 32'(grant1_out), 32'd0);
        cyc();
        check("abort_then_g1", 32'(grant1_out), 32'd1);

        // Non-owner strobes are dropped; data shows the owner.
        data1_in      = 8'h11;
        data0_in      = 8'h3C;
        write_stb0_in = 1'b1;
        sync_stb0_in  = 1'b1;
        #1;
        check("nonowner_write", 32'(oled_write_stb_out), 32'd0);
        check("nonowner_sync", 32'(oled_sync_stb_out), 32'd0);
        check("nonowner_data", 32'(oled_data_out), 32'h11);
        cyc();
        write_stb0_in = 1'b0;
        sync_stb0_in  = 1'b0;
        drive_write(1, 8'h5A);

        // Abort waits for the driver to be idle.
        oled_ready_in = 1'b0;
        req1_in       = 1'b0;
        cyc();
        check("abort_deferred", 32'(grant1_out), 32'd1);
        check("ready1_low", 32'(ready1_out), 32'd0);
        oled_ready_in = 1'b1;
        cyc();
        check("abort_done", 32'(grant1_out), 32'd0);

        // No grant while the driver is busy.
        oled_ready_in = 1'b0;
        req0_in       = 1'b1;
        cyc();
        cyc();
        check("busy_no_grant", 32'(grant0_out), 32'd0);
        oled_ready_in = 1'b1;
        cyc();
        check("idle_grant0", 32'(grant0_out), 32'd1);

        // Write and sync together: both forwarded, then sync handshake.
        data0_in      = 8'h77;
        write_stb0_in = 1'b1;
        sync_stb0_in  = 1'b1;
        sb_q.push_back(8'h77);
        #1;
        check("ws_sync", 32'(oled_sync_stb_out), 32'd1);
        check("ws_write", 32'(oled_write_stb_out), 32'd1);
        check("ws_data", 32'(oled_data_out), 32'h77);
        cyc();
        write_stb0_in = 1'b0;
        sync_stb0_in  = 1'b0;
        req1_in       = 1'b1;
        check("sync_busy_g0", 32'(grant0_out), 32'd0);
        cyc();
        check("no_regrant_busy", 32'(grant0_out | grant1_out), 32'd0);
        oled_ready_in = 1'b0;
        cyc();
        cyc();
        check("sync_done_nogrant", 32'(grant0_out | grant1_out), 32'd0);
        oled_ready_in = 1'b1;
        cyc();
        check("back_idle", 32'(grant0_out | grant1_out), 32'd0);
        cyc();
        check("rr_after_sync_g1", 32'(grant1_out), 32'd1);
        check("rr_after_sync_g0", 32'(grant0_out), 32'd0);

        // Asynchronous reset mid-frame kills the grant and strobes at once.
        data1_in      = 8'h99;
        write_stb1_in = 1'b1;
        reset_n_in    = 1'b0;
        #1;
        check("midrst_grant1", 32'(grant1_out), 32'd0);
        check("midrst_write", 32'(oled_write_stb_out), 32'd0);
        check("midrst_data", 32'(oled_data_out), 32'd0);
        check("midrst_sync", 32'(oled_sync_stb_out), 32'd0);
        cyc();
        write_stb1_in = 1'b0;
        reset_n_in    = 1'b1;
        req0_in       = 1'b0;
        req1_in       = 1'b1;
        #1;
        check("midrst_rerequest", 32'(grant1_out), 32'd0);
        cyc();
        check("fresh_arb_g1", 32'(grant1_out), 32'd1);

        reset_n_in = 1'b0;
        #1;
        reset_n_in = 1'b1;
        req0_in    = 1'b1;
        req1_in    = 1'b1;
        cyc();
        check("fresh_rr_g0", 32'(grant0_out), 32'd1);
        check("fresh_rr_g1", 32'(grant1_out), 32'd0);
        req0_in = 1'b0;
        req1_in = 1'b0;
        cyc();
        cyc();

        // Two contending streams with a busy driver: strict alternation.
        reset_n_in = 1'b0;
        cyc();
        reset_n_in    = 1'b1;
        req0_in       = 1'b1;
        req1_in       = 1'b1;
        oled_ready_in = 1'b1;
        drv_busy      = 0;
        drv_en        = 1'b1;
        for (int f = 0; f < 4; f++) begin
            n = 0;
            while ((grant0_out | grant1_out) !== 1'b1 && n < 40) begin
                cyc();
                n++;
            end
            check("rr_grant_arrived", 32'(grant0_out | grant1_out), 32'd1);
            owner = (grant1_out === 1'b1) ? 1 : 0;
            check("rr_grant_order", 32'(owner), 32'(f % 2));
            send_frame(owner, 8'(8'h20 + 8'(f * 16)));
        end
        req0_in = 1'b0;
        req1_in = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        drv_en        = 1'b0;
        oled_ready_in = 1'b1;
        cyc();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

`ifdef OLED_ARB_WATCHDOG_EN
        // Silent owner is released by the watchdog 16 cycles after its last strobe.
        reset_n_in = 1'b0;
        cyc();
        reset_n_in = 1'b1;
        req1_in    = 1'b1;
        cyc();
        check("wd_grant1", 32'(grant1_out), 32'd1);
        drive_write(1, 8'hC3);
        for (int k = 1; k <= 16; k++) begin
            check("wd_timeout", 32'(timeout_out), 32'(k == 16));
            check("wd_hold", 32'(grant1_out), 32'd1);
            if (k < 16) cyc();
        end
        cyc();
        check("wd_release", 32'(grant1_out), 32'd0);
        check("wd_pulse_end", 32'(timeout_out), 32'd0);
        req1_in = 1'b0;
        cyc();
        cyc();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
